// File: rtl/sub_pkg.sv
// Shared definitions for the serial subtractor.
// Holds the controller state type and a helper that sizes the chunk index.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-chunk operation still needs a one-bit index register.
  function automatic int idx_width(input int n_chunks);
    return (n_chunks > 1) ? $clog2(n_chunks) : 1;
  endfunction

endpackage

// File: rtl/sub_chunk.sv
// Combinational W-bit subtract slice with borrow chain.
// Ports:
//   x, y  : minuend / subtrahend slice
//   bin   : borrow in from the lower slice
//   d     : (x - y - bin) mod 2^W
//   bout  : borrow out (1 when x < y + bin)
module sub_chunk #(
  parameter int W = 2
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         bin,
  output logic [W-1:0] d,
  output logic         bout
);

  logic [W:0] t;

  // One extra bit catches the borrow: it goes high exactly when the
  // unsigned difference wraps below zero.
  assign t    = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bin};
  assign d    = t[W-1:0];
  assign bout = t[W];

endmodule

// File: rtl/sub_serial.sv
// Serial unsigned subtractor: captures a and b, then resolves CHUNK bits
// per cycle from the LSB up, carrying the borrow between chunks.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (ready only while idle)
//   a, b                 : minuend, subtrahend (sampled on accept)
//   out_valid / out_ready: result handshake (valid only when done)
//   diff                 : (a - b) mod 2^N
//   borrow               : 1 when a < b
module sub_serial
  import sub_pkg::*;
#(
  parameter int N     = 8,
  parameter int CHUNK = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         borrow
);

  localparam int NCH   = N / CHUNK;
  localparam int IDX_W = idx_width(NCH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCH - 1);

  generate
    if (N % CHUNK != 0) begin : g_bad_chunk
      $error("sub_serial: N must be a multiple of CHUNK");
    end
  endgenerate

  state_t           state_q;
  logic [N-1:0]     a_q, b_q;
  logic [N-1:0]     diff_q;
  logic             borrow_q;
  logic [IDX_W-1:0] idx_q;
  logic             in_ready_q, out_valid_q;

  // Captured operands split into chunks; the single slice below is fed
  // from whichever chunk idx_q points at.
  logic [CHUNK-1:0] a_ch [NCH];
  logic [CHUNK-1:0] b_ch [NCH];

  for (genvar gi = 0; gi < NCH; gi++) begin : g_slice
    assign a_ch[gi] = a_q[gi*CHUNK +: CHUNK];
    assign b_ch[gi] = b_q[gi*CHUNK +: CHUNK];
  end

  logic [CHUNK-1:0] chunk_d;
  logic             bout_d;

  sub_chunk #(.W(CHUNK)) u_chunk (
    .x    (a_ch[idx_q]),
    .y    (b_ch[idx_q]),
    .bin  (borrow_q),
    .d    (chunk_d),
    .bout (bout_d)
  );

  // borrow_q doubles as the running borrow accumulator while busy; after
  // the top chunk it holds the final borrow, which is what DONE presents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          diff_q[idx_q*CHUNK +: CHUNK] <= chunk_d;
          borrow_q <= bout_d;
          idx_q    <= idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign borrow    = borrow_q;

  // The finished {borrow, diff} must equal the full-width difference of
  // the captured operands.
  always_comb begin
    if (state_q == DONE) begin
      assert ({borrow_q, diff_q} == ({1'b0, a_q} - {1'b0, b_q}))
        else $error("sub_serial: a=%h b=%h diff=%h", a_q, b_q, diff_q);
    end
  end

endmodule
